// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified RAM between instruction fetch and
// load/store traffic; data wins in IDLE, squashed fetches are dropped, and RAM stalls time out.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              flush,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              stall_mem,
    output logic              stall_if,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DBUSY = 2'd1,
        IBUSY = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic             squash_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_next_s;

    logic data_req_s;
    logic issue_d_s;
    logic issue_i_s;
    logic busy_s;
    logic done_d_s;
    logic done_i_s;
    logic squash_hit_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: data priority is only decided in IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (issue_d_s) begin
                    state_next_s = DBUSY;
                end else if (issue_i_s) begin
                    state_next_s = IBUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DBUSY: begin
                if (ram_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DBUSY;
                end
            end
            IBUSY: begin
                if (ram_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = IBUSY;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output/strobe decode; a flush on the completing cycle still squashes.
    always_comb begin
        data_req_s   = mem_read | mem_write;
        issue_d_s    = 1'b0;
        issue_i_s    = 1'b0;
        busy_s       = 1'b0;
        done_d_s     = 1'b0;
        done_i_s     = 1'b0;
        squash_hit_s = squash_r | flush;
        case (state_r)
            IDLE: begin
                if (data_req_s) begin
                    issue_d_s = 1'b1;
                end else if (if_req && !flush) begin
                    issue_i_s = 1'b1;
                end else begin
                    issue_d_s = 1'b0;
                end
            end
            DBUSY: begin
                busy_s   = 1'b1;
                done_d_s = ram_ready;
            end
            IBUSY: begin
                busy_s   = 1'b1;
                done_i_s = ram_ready;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
        stall_mem = data_req_s & ~d_valid;
        stall_if  = stall_mem | (if_req & ~if_valid);
    end

    // Request registers drive the RAM and stay stable through the transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= {ADDR_W{1'b0}};
            ram_wdata <= {DATA_W{1'b0}};
        end else if (issue_d_s) begin
            ram_req   <= 1'b1;
            ram_we    <= mem_write;
            ram_addr  <= d_addr;
            ram_wdata <= d_wdata;
        end else if (issue_i_s) begin
            ram_req   <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= if_addr;
            ram_wdata <= ram_wdata;
        end else if (done_d_s || done_i_s) begin
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= ram_addr;
            ram_wdata <= ram_wdata;
        end else begin
            ram_req   <= ram_req;
            ram_we    <= ram_we;
            ram_addr  <= ram_addr;
            ram_wdata <= ram_wdata;
        end
    end

    // Completion: capture read data and emit one-cycle valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_valid  <= 1'b0;
            if_valid <= 1'b0;
            d_rdata  <= {DATA_W{1'b0}};
            if_rdata <= {DATA_W{1'b0}};
        end else begin
            d_valid  <= done_d_s;
            if_valid <= done_i_s & ~squash_hit_s;
            if (done_d_s && !ram_we) begin
                d_rdata <= ram_rdata;
            end else begin
                d_rdata <= d_rdata;
            end
            if (done_i_s && !squash_hit_s) begin
                if_rdata <= ram_rdata;
            end else begin
                if_rdata <= if_rdata;
            end
        end
    end

    // Squash lives only while the fetch it belongs to is still in IBUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            squash_r <= 1'b0;
        end else if ((state_r == IBUSY) && !ram_ready) begin
            squash_r <= squash_r | flush;
        end else begin
            squash_r <= 1'b0;
        end
    end

    // Saturating wait counter; cleared whenever a new transaction is issued.
    always_comb begin
        wait_cnt_next_s = wait_cnt_r;
        if (issue_d_s || issue_i_s) begin
            wait_cnt_next_s = {CNT_W{1'b0}};
        end else if (busy_s && !ram_ready && (wait_cnt_r != CNT_MAX)) begin
            wait_cnt_next_s = wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_next_s = wait_cnt_r;
        end
    end

    // Wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {CNT_W{1'b0}};
            err        <= 1'b0;
        end else begin
            wait_cnt_r <= wait_cnt_next_s;
            if (busy_s && !ram_ready && (wait_cnt_next_s == CNT_MAX)) begin
                err <= 1'b1;
            end else begin
                err <= err;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified instruction/data RAM between the IF stage (instruction fetch) and the MEM stage (load/store driven by the control unit's memRead/memWrite). It serialises accesses through a three-state FSM, gives data accesses fixed priority, and generates the stall signals that freeze the pipeline while a transaction is outstanding. It also discards fetches squashed by a taken branch or jump, and flags RAM timeouts.

## Interface
- ADDR_W, 32, address width (byte address, passed through unmodified)
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles ram_req may wait for ram_ready before err sets; counter width is clog2(TIMEOUT+1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF stage requests instruction at if_addr
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid when if_valid=1
- if_valid  out  1  one-cycle pulse, fetch complete
- flush  in  1  taken branch/jump this cycle (pcSrc != 0); squashes the in-flight/pending fetch
- mem_read  in  1  MEM stage load
- mem_write  in  1  MEM stage store
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid when d_valid=1
- d_valid  out  1  one-cycle pulse, data access complete
- stall_mem  out  1  freeze entire pipeline
- stall_if  out  1  freeze PC and IF/ID register
- ram_req, ram_we  out  1  RAM request / write enable
- ram_addr  out  ADDR_W; ram_wdata  out  DATA_W
- ram_rdata  in  DATA_W; ram_ready  in  1  RAM completes the request in this cycle
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, DBUSY, IBUSY.
- IDLE:
  - If mem_read|mem_write: latch d_addr, d_wdata, and we=mem_write into the request registers; go to DBUSY.
  - Else if if_req and !flush: latch if_addr, we=0; go to IBUSY.
  - Else stay in IDLE.
- mem_read and mem_write together: treated as a write.
- DBUSY/IBUSY:
  - ram_req=1 and ram_addr/ram_we/ram_wdata are driven from the request registers, which are stable for the whole transaction.
  - On ram_ready=1: capture ram_rdata into d_rdata or if_rdata, pulse the matching valid for the next cycle, return to IDLE.
  - A store also pulses d_valid; d_rdata is then unchanged.
- Flush:
  - A flush during IBUSY sets squash. The RAM transaction still completes because it cannot be aborted, but if_valid is suppressed and if_rdata is not updated.
  - squash clears on leaving IBUSY.
  - A flush in IDLE blocks that cycle's fetch issue.
- stall_mem = (mem_read|mem_write) & !d_valid (combinational).
- stall_if = stall_mem | (if_req & !if_valid) (combinational).
- Timeout:
  - A wait counter clears on entering a busy state and increments each busy cycle with ram_ready=0, saturating.
  - When the counter reaches TIMEOUT, err sets. The FSM keeps waiting.
  - err is cleared only by rst.

## Timing
- Reset values: state=IDLE, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, if_rdata=0, d_rdata=0, if_valid=0, d_valid=0, squash=0, counter=0, err=0.
- Latency, request seen in IDLE at cycle N:
  - ram_req=1 from N+1.
  - ram_ready at cycle M≥N+1 gives valid=1 at M+1, state=IDLE at M+1.
  - Minimum latency is therefore 2 cycles.
- Valid pulses last exactly one cycle.
- The next request can be accepted in IDLE in the same cycle the valid pulse is seen. The pipeline advances on that edge, so the MEM inputs already reflect the next instruction.
- Data-over-fetch priority is evaluated only in IDLE. An in-flight fetch is never pre-empted; a data request arriving during IBUSY waits and stalls the pipeline.
- ram_ready while in IDLE is ignored.
- rst mid-transaction: next cycle state=IDLE with ram_req=0. No valid pulses for the abandoned transaction.

## Test plan
- Fetch only: if_req=1, if_addr=0x40, ram_ready 3 cycles after ram_req rises, ram_rdata=0x8C220004 -> ram_req high 3 cycles; then if_valid=1 for 1 cycle with if_rdata=0x8C220004; stall_if high until then.
- Contention: if_req=1 and mem_read=1 with d_addr=0x100 in the same IDLE cycle, ram_ready=1 every cycle -> ram_addr=0x100 first with d_valid at cycle 2; fetch issues next, if_valid at cycle 4; stall_mem low from cycle 2.
- Store: mem_write=1, d_addr=0x20, d_wdata=0xDEADBEEF, ram_ready immediate -> ram_we=1, ram_wdata=0xDEADBEEF for 1 cycle; d_valid pulse; d_rdata unchanged.
- Flush: fetch in IBUSY, flush=1 one cycle before ram_ready -> no if_valid, if_rdata keeps its old value; state IDLE afterwards; the next fetch behaves normally.
- Timeout: TIMEOUT=4, ram_ready held 0 -> err=1 after the 4th busy cycle and stays 1 after ram_ready later completes; cleared only by rst.
- Reset mid-op: rst=1 in DBUSY -> next cycle ram_req=0, d_valid=0, stall_mem follows the mem_read/mem_write inputs, err=0.
